fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the LEGv8 five-stage pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the 64-bit program counter and runs a request/acknowledge handshake with a variable-latency instruction memory. It presents each fetched instruction with its PC to IF/ID, and honours hazard-unit stalls and branch redirects from later stages.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset; low 2 bits must be 0
- clock_In  input  1  pipeline clock; all state changes on its rising edge
- reset_In  input  1  asynchronous, active-low reset
- stall_In  input  1  hazard unit: hold outputs, do not advance PC
- branchTaken_In  input  1  redirect request from a later stage; also flushes
- branchTarget_In  input  64  redirect address; bits [1:0] ignored and forced to 0
- imemAck_In  input  1  memory: imemData_In is valid this cycle
- imemData_In  input  32  instruction word returned by memory
- imemReq_Out  output  1  fetch request; held high until acknowledged
- imemAddr_Out  output  64  fetch address; stable while imemReq_Out is high
- instr_Out  output  32  instruction to IF/ID instr_In
- pcOut_Out  output  64  PC of instr_Out, to IF/ID pcOut_In
- valid_Out  output  1  instr_Out/pcOut_Out hold a real instruction (0 = bubble)

## Operation
- Registers:
  - pc (64)
  - state: REQ, HOLD or DROP
  - holdInstr (32)
  - pendPc (64)
  - output registers: instr_Out, pcOut_Out, valid_Out
- Reset, asynchronous on reset_In low:
  - pc = RESET_PC; state = REQ
  - instr_Out = 32'h0, pcOut_Out = 64'h0, valid_Out = 0
  - imemReq_Out = 0
- imemAddr_Out = pc in REQ, and in DROP (the address still outstanding).
- imemReq_Out = 1 in REQ and DROP, 0 in HOLD; forced 0 while reset_In is low.
- Priority each cycle: branchTaken_In > stall_In > normal advance.
- REQ:
  - branchTaken_In=1 with ack: discard data; pc <= target; valid_Out <= 0; stay REQ.
  - branchTaken_In=1 without ack: pendPc <= target; valid_Out <= 0; go DROP.
  - Ack and stall_In=0: instr_Out <= imemData_In; pcOut_Out <= pc; valid_Out <= 1; pc <= pc+4.
  - Ack and stall_In=1: holdInstr <= imemData_In; outputs unchanged; go HOLD.
  - No ack, stall_In=0: valid_Out <= 0 (bubble). No ack, stall_In=1: outputs unchanged.
- HOLD:
  - branchTaken_In=1: drop holdInstr; pc <= target; valid_Out <= 0; go REQ.
  - stall_In=0: instr_Out <= holdInstr; pcOut_Out <= pc; valid_Out <= 1; pc <= pc+4; go REQ.
  - stall_In=1: everything holds.
- DROP:
  - branchTaken_In=1: pendPc <= new target (latest redirect wins); valid_Out <= 0.
  - Ack: discard data; pc <= pendPc, or the new target if a redirect arrives the same cycle; go REQ.
  - valid_Out stays 0 throughout DROP.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
- stall_In has no effect on pc or outputs when branchTaken_In=1: flush overrides stall.

## Timing
- With zero-wait memory (ack in the same cycle as the request), throughput is 1 instruction per cycle.
- Fetch-to-output latency: ack in cycle t gives valid_Out=1 with that word in cycle t+1.
- Redirect at cycle t:
  - valid_Out=0 in cycle t+1.
  - imemAddr_Out=target in cycle t+1 if no request was outstanding or ack arrived at t.
  - Otherwise imemAddr_Out=target in the cycle after the late ack.
- Requests are never withdrawn. Once imemReq_Out rises, imemAddr_Out does not change until the cycle after imemAck_In.
- imemAck_In while imemReq_Out=0 is a protocol error; it is ignored.
- Reset released mid-transaction: no request survives reset, and the first request after release is to RESET_PC.
- A stall released in cycle t from HOLD gives the buffered word on the outputs at t+1; the new request at pc+4 is issued at t+1.

## Test plan
- Reset with RESET_PC=0x100 and zero-wait ack of words A, B, C:
  - imemAddr_Out sequence is 0x100, 0x104, 0x108.
  - Outputs are (A,0x100), (B,0x104), (C,0x108) on consecutive cycles, all with valid_Out=1.
- Ack with 3-cycle latency:
  - imemAddr_Out is held 0x100 for 3 cycles.
  - valid_Out=0 for 2 cycles, then (A,0x100) valid one cycle after the ack.
- stall_In high for 4 cycles, ack arriving during the stall:
  - Outputs frozen; state goes to HOLD with imemReq_Out=0.
  - After release, (B,0x104) appears one cycle later, then the fetch from 0x108 starts.
- branchTaken_In, target 0x2003, pulsed while a request is outstanding:
  - valid_Out=0 next cycle; the late-acked word is dropped.
  - The next imemAddr_Out is 0x2000 and the next valid output is (X,0x2000).
- Simultaneous stall_In=1 and branchTaken_In=1 in HOLD:
  - Buffer is discarded, valid_Out=0, and a fetch from the target starts the next cycle.
- PC wrap and async reset:
  - RESET_PC=64'hFFFF_FFFF_FFFF_FFFC fetches, then the next address is 0.
  - reset_In pulsed low mid-request clears valid_Out and imemReq_Out immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: one request/acknowledge channel.
// Handshake: the master raises imemReq_Out with a stable imemAddr_Out and holds both
// until the slave pulses imemAck_In with imemData_In valid in that same cycle;
// requests are never withdrawn, and an ack seen while imemReq_Out is low is ignored.
interface fetch_stage_if;
   logic        imemReq_Out;
   logic [63:0] imemAddr_Out;
   logic        imemAck_In;
   logic [31:0] imemData_In;

   modport master (output imemReq_Out, output imemAddr_Out,
                   input  imemAck_In,  input  imemData_In);
   modport slave  (input  imemReq_Out, input  imemAddr_Out,
                   output imemAck_In,  output imemData_In);
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and feeds IF/ID, honouring stalls and branch redirects.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                 clock_In,
   input  logic                 reset_In,
   input  logic                 stall_In,
   input  logic                 branchTaken_In,
   input  logic [63:0]          branchTarget_In,
   fetch_stage_if.master        imem,
   output logic [31:0]          instr_Out,
   output logic [63:0]          pcOut_Out,
   output logic                 valid_Out,
   output logic [1:0]           state_dbg_Out
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [63:0] pend_q, pend_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   logic        req;
   logic        ack_eff;
   logic [63:0] target;

   // Request is gated by reset so it drops the instant reset asserts.
   assign req     = reset_In && (state_q != S_HOLD);
   assign ack_eff = imem.imemAck_In && req;
   assign target  = {branchTarget_In[63:2], 2'b00};

   assign imem.imemReq_Out  = req;
   assign imem.imemAddr_Out = pc_q;
   assign instr_Out         = instr_q;
   assign pcOut_Out         = pc_out_q;
   assign valid_Out         = valid_q;
   assign state_dbg_Out     = state_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      hold_d   = hold_q;
      pend_d   = pend_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      case (state_q)
         S_REQ: begin
            if (branchTaken_In) begin
               valid_d = 1'b0;
               if (ack_eff) begin
                  pc_d = target;
               end else begin
                  pend_d  = target;
                  state_d = S_DROP;
               end
            end else if (ack_eff) begin
               if (stall_In) begin
                  hold_d  = imem.imemData_In;
                  state_d = S_HOLD;
               end else begin
                  instr_d  = imem.imemData_In;
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + 64'd4;
               end
            end else if (!stall_In) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (branchTaken_In) begin
               pc_d    = target;
               valid_d = 1'b0;
               state_d = S_REQ;
            end else if (!stall_In) begin
               instr_d  = hold_q;
               pc_out_d = pc_q;
               valid_d  = 1'b1;
               pc_d     = pc_q + 64'd4;
               state_d  = S_REQ;
            end
         end
         S_DROP: begin
            // The outstanding fetch is stale; only its ack lets us move to the redirect.
            valid_d = 1'b0;
            if (ack_eff) begin
               pc_d    = branchTaken_In ? target : pend_q;
               state_d = S_REQ;
            end else if (branchTaken_In) begin
               pend_d = target;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clock_In or negedge reset_In) begin
      if (!reset_In) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         hold_q   <= 32'h0;
         pend_q   <= 64'h0;
         instr_q  <= 32'h0;
         pc_out_q <= 64'h0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         hold_q   <= hold_d;
         pend_q   <= pend_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset and PC-wrap sequences,
// then random traffic scored against a queue-based behavioural model.
module tb_fetch_stage;
   localparam int W = 162;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br;
   logic [63:0] tgt;
   logic [31:0] instr, w_instr;
   logic [63:0] pc_out, w_pc_out;
   logic        valid, w_valid;
   logic [1:0]  st_dbg, w_st_dbg;

   int errors = 0;
   int checks = 0;

   fetch_stage_if imem_if ();
   fetch_stage_if wif ();

   fetch_stage #(.RESET_PC(64'h100)) dut (
      .clock_In(clk), .reset_In(rst_n), .stall_In(stall), .branchTaken_In(br),
      .branchTarget_In(tgt), .imem(imem_if.master), .instr_Out(instr),
      .pcOut_Out(pc_out), .valid_Out(valid), .state_dbg_Out(st_dbg));

   fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
      .clock_In(clk), .reset_In(rst_n), .stall_In(1'b0), .branchTaken_In(1'b0),
      .branchTarget_In(64'h0), .imem(wif.master), .instr_Out(w_instr),
      .pcOut_Out(w_pc_out), .valid_Out(w_valid), .state_dbg_Out(w_st_dbg));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // packed view {req, addr, valid, instr, pc}
   function automatic logic [W-1:0] pack(input logic r, input logic [63:0] a, input logic v,
                                         input logic [31:0] i, input logic [63:0] p);
      return {r, a, v, i, p};
   endfunction

   function automatic logic [W-1:0] dut_now();
      return pack(imem_if.imemReq_Out, imem_if.imemAddr_Out, valid, instr, pc_out);
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h, want req=%0b addr=%h valid=%0b instr=%h pc=%h",
                  name, act[161], act[160:97], act[96], act[95:64], act[63:0],
                  exp[161], exp[160:97], exp[96], exp[95:64], exp[63:0]);
      end
   endtask

   // driver
   task automatic drive(input logic b, input logic [63:0] t, input logic s,
                        input logic a, input logic [31:0] d);
      br = b; tgt = t; stall = s;
      imem_if.imemAck_In = a; imem_if.imemData_In = d;
   endtask

   // directed vectors: inputs for one cycle, outputs expected after that edge
   typedef struct {
      logic        br;
      logic [63:0] tgt;
      logic        stall;
      logic        ack;
      logic [31:0] data;
      logic        exp_req;
      logic [63:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(input logic b, input logic [63:0] t, input logic s, input logic a,
                               input logic [31:0] d, input logic r, input logic [63:0] ad,
                               input logic v, input logic [31:0] i, input logic [63:0] p);
      vec_t x;
      x.br = b; x.tgt = t; x.stall = s; x.ack = a; x.data = d;
      x.exp_req = r; x.exp_addr = ad; x.exp_valid = v; x.exp_instr = i; x.exp_pc = p;
      return x;
   endfunction

   // behavioural reference: PC, a one-deep buffer of stalled words, a stale-fetch flag
   logic [63:0] m_pc, m_redir, m_pcout;
   logic [31:0] m_instr;
   logic        m_valid, m_drop;
   logic [31:0] m_buf[$];
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] model_view();
      return pack(m_buf.size() == 0, m_pc, m_valid, m_instr, m_pcout);
   endfunction

   task automatic model_reset();
      m_pc = 64'h100; m_redir = 64'h0; m_pcout = 64'h0; m_instr = 32'h0;
      m_valid = 1'b0; m_drop = 1'b0; m_buf.delete();
   endtask

   task automatic model_step(input logic b, input logic [63:0] t, input logic s,
                             input logic a, input logic [31:0] d);
      logic [63:0] aligned;
      logic        got;
      aligned = t & ~64'h3;
      got = a && (m_buf.size() == 0);
      if (m_buf.size() != 0) begin
         if (b) begin
            m_buf.delete(); m_pc = aligned; m_valid = 1'b0;
         end else if (!s) begin
            m_instr = m_buf.pop_front(); m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
         end
      end else if (m_drop) begin
         m_valid = 1'b0;
         if (got) begin
            m_pc = b ? aligned : m_redir; m_drop = 1'b0;
         end else if (b) begin
            m_redir = aligned;
         end
      end else if (b) begin
         m_valid = 1'b0;
         if (got) m_pc = aligned;
         else begin m_drop = 1'b1; m_redir = aligned; end
      end else if (got) begin
         if (s) m_buf.push_back(d);
         else begin m_instr = d; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4; end
      end else if (!s) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      drive(1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
      wif.imemAck_In = 1'b0; wif.imemData_In = 32'h0;

      vecs[0]  = mk(0, 0, 0, 1, 32'hA000_0001, 1, 64'h104, 1, 32'hA000_0001, 64'h100);
      vecs[1]  = mk(0, 0, 0, 1, 32'hB000_0002, 1, 64'h108, 1, 32'hB000_0002, 64'h104);
      vecs[2]  = mk(0, 0, 0, 1, 32'hC000_0003, 1, 64'h10C, 1, 32'hC000_0003, 64'h108);
      vecs[3]  = mk(0, 0, 0, 0, 32'hDEAD_0000, 1, 64'h10C, 0, 32'hC000_0003, 64'h108);
      vecs[4]  = mk(0, 0, 0, 0, 32'hDEAD_0001, 1, 64'h10C, 0, 32'hC000_0003, 64'h108);
      vecs[5]  = mk(0, 0, 0, 1, 32'hD000_0004, 1, 64'h110, 1, 32'hD000_0004, 64'h10C);
      vecs[6]  = mk(0, 0, 1, 0, 32'hDEAD_0002, 1, 64'h110, 1, 32'hD000_0004, 64'h10C);
      vecs[7]  = mk(0, 0, 1, 1, 32'hE000_0005, 0, 64'h110, 1, 32'hD000_0004, 64'h10C);
      vecs[8]  = mk(0, 0, 1, 1, 32'hDEAD_0003, 0, 64'h110, 1, 32'hD000_0004, 64'h10C);
      vecs[9]  = mk(0, 0, 1, 0, 32'hDEAD_0004, 0, 64'h110, 1, 32'hD000_0004, 64'h10C);
      vecs[10] = mk(0, 0, 0, 0, 32'hDEAD_0005, 1, 64'h114, 1, 32'hE000_0005, 64'h110);
      vecs[11] = mk(0, 0, 0, 1, 32'hF000_0006, 1, 64'h118, 1, 32'hF000_0006, 64'h114);
      vecs[12] = mk(1, 64'h2003, 0, 0, 32'hDEAD_0006, 1, 64'h118, 0, 32'hF000_0006, 64'h114);
      vecs[13] = mk(0, 0, 0, 0, 32'hDEAD_0007, 1, 64'h118, 0, 32'hF000_0006, 64'h114);
      vecs[14] = mk(0, 0, 0, 1, 32'h6666_0007, 1, 64'h2000, 0, 32'hF000_0006, 64'h114);
      vecs[15] = mk(0, 0, 0, 1, 32'h1234_5678, 1, 64'h2004, 1, 32'h1234_5678, 64'h2000);
      vecs[16] = mk(0, 0, 1, 1, 32'h7777_0008, 0, 64'h2004, 1, 32'h1234_5678, 64'h2000);
      vecs[17] = mk(1, 64'h3000, 1, 0, 32'hDEAD_0008, 1, 64'h3000, 0, 32'h1234_5678, 64'h2000);
      vecs[18] = mk(0, 0, 0, 1, 32'h8888_0009, 1, 64'h3004, 1, 32'h8888_0009, 64'h3000);
      vecs[19] = mk(1, 64'h401, 0, 1, 32'hDEAD_0009, 1, 64'h400, 0, 32'h8888_0009, 64'h3000);
      vecs[20] = mk(0, 0, 0, 1, 32'h9999_000A, 1, 64'h404, 1, 32'h9999_000A, 64'h400);
      vecs[21] = mk(1, 64'h5000, 0, 0, 32'hDEAD_000A, 1, 64'h404, 0, 32'h9999_000A, 64'h400);
      vecs[22] = mk(1, 64'h6002, 0, 0, 32'hDEAD_000B, 1, 64'h404, 0, 32'h9999_000A, 64'h400);
      vecs[23] = mk(0, 0, 0, 1, 32'hDEAD_000C, 1, 64'h6000, 0, 32'h9999_000A, 64'h400);
      vecs[24] = mk(0, 0, 0, 1, 32'hAAAA_000D, 1, 64'h6004, 1, 32'hAAAA_000D, 64'h6000);

      // reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", dut_now(), pack(1'b0, 64'h100, 1'b0, 32'h0, 64'h0));
      check("reset_wrap", pack(wif.imemReq_Out, wif.imemAddr_Out, w_valid, w_instr, w_pc_out),
            pack(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 64'h0));
      rst_n = 1'b1;
      #1;
      check("first_req", dut_now(), pack(1'b1, 64'h100, 1'b0, 32'h0, 64'h0));

      // PC wrap on the second instance
      wif.imemAck_In = 1'b1; wif.imemData_In = 32'hFACE_0001;
      @(negedge clk);
      wif.imemAck_In = 1'b0;
      check("pc_wrap", pack(wif.imemReq_Out, wif.imemAddr_Out, w_valid, w_instr, w_pc_out),
            pack(1'b1, 64'h0, 1'b1, 32'hFACE_0001, 64'hFFFF_FFFF_FFFF_FFFC));
      check("idle_bubble", dut_now(), pack(1'b1, 64'h100, 1'b0, 32'h0, 64'h0));

      // directed table
      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].br, vecs[i].tgt, vecs[i].stall, vecs[i].ack, vecs[i].data);
         @(negedge clk);
         check($sformatf("vec%0d", i), dut_now(),
               pack(vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
                    vecs[i].exp_instr, vecs[i].exp_pc));
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0, 32'h0);

      // async reset mid-request, checked between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", dut_now(), pack(1'b0, 64'h100, 1'b0, 32'h0, 64'h0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_req", dut_now(), pack(1'b1, 64'h100, 1'b0, 32'h0, 64'h0));

      // random traffic against the model
      model_reset();
      exp_q.push_back(model_view());
      for (int n = 0; n < 3000; n++) begin
         logic        rb, rs, ra;
         logic [63:0] rt;
         logic [31:0] rd;
         @(negedge clk);
         check($sformatf("rand%0d", n), dut_now(), exp_q.pop_front());
         rb = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 3) == 0);
         ra = ($urandom_range(0, 1) == 1);
         rt = {$urandom(), $urandom()};
         rd = $urandom();
         drive(rb, rt, rs, ra, rd);
         model_step(rb, rt, rs, ra, rd);
         exp_q.push_back(model_view());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
